// File: rtl/phy_pkg.sv
// Symbol codes, FSM state encoding and link defaults shared by the PHY transmitter and receiver.
package phy_pkg;

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_IDLE = 8'h7C;

  localparam int COM_COUNT_DEF  = 4;
  localparam int COM_PERIOD_DEF = 16;

  typedef enum logic {
    ST_PREAMBLE = 1'b0,
    ST_LINK     = 1'b1
  } phy_state_t;

endpackage

// File: rtl/piso_shift8.sv
// 8-bit MSB-first serializer: loads i_sym when the bit counter is 0; each bit appears one clock after its slot.
// Free-running, no backpressure; o_sym_start marks the clock serial carries bit 7.
module piso_shift8 (
  input  logic       i_clk_1,
  input  logic       i_reset,
  input  logic [7:0] i_sym,
  output logic [2:0] o_bit_cnt,
  output logic       o_load,
  output logic       o_serial,
  output logic       o_sym_start
);

  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_serial;
  logic       r_sym_start;

  assign o_load = (r_bit_cnt == 3'd0);

  // On the load edge r_shift[7] still holds bit 0 of the outgoing symbol.
  always_ff @(posedge i_clk_1) begin
    if (!i_reset) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_serial    <= 1'b0;
      r_sym_start <= 1'b0;
    end else begin
      r_bit_cnt   <= r_bit_cnt + 3'd1;
      r_serial    <= r_shift[7];
      r_sym_start <= (r_bit_cnt == 3'd1);
      if (o_load) begin
        r_shift <= i_sym;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

  assign o_bit_cnt   = r_bit_cnt;
  assign o_serial    = r_serial;
  assign o_sym_start = r_sym_start;

endmodule

// File: rtl/paralelo_serial_phytx.sv
// Parallel-to-serial PHY TX: COM preamble, then DATA/IDLE symbols; byte accepted on edge N shows MSB after N+2.
// valid/ready: one byte per symbol, ready_out only in the last bit slot. Optional COM_PERIODIC_EN re-inserts COM in idle runs.
module paralelo_serial_phytx
  import phy_pkg::*;
#(
  parameter int COM_COUNT  = COM_COUNT_DEF,
  parameter int COM_PERIOD = COM_PERIOD_DEF
) (
  input  logic       clk_1,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out,
  output logic       sym_start,
  output logic       active_out
);

  localparam int CCW = (COM_COUNT > 0) ? $clog2(COM_COUNT + 1) : 1;

  phy_state_t     r_state;
  phy_state_t     w_state_nxt;
  logic [CCW-1:0] r_com_cnt;
  logic           r_pend;
  logic [7:0]     r_data;
  logic           r_ready;
  logic           r_active;

  logic [2:0]     w_bit_cnt;
  logic           w_load;
  logic [7:0]     w_sym;
  logic           w_com_done;
  logic           w_send_com;
  logic           w_link_win;
  logic           w_period_com;
  logic           w_xfer;

  assign w_com_done = (r_com_cnt == CCW'(COM_COUNT));
  assign w_xfer     = valid_in && r_ready;

  always_ff @(posedge clk_1) begin
    if (!reset) begin
      r_state <= ST_PREAMBLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_PREAMBLE) && w_load && w_com_done) begin
      w_state_nxt = ST_LINK;
    end
  end

  // The last preamble COM already opens the handshake window so the first LINK symbol can carry data.
  always_comb begin
    w_send_com = 1'b0;
    w_link_win = 1'b0;
    case (r_state)
      ST_PREAMBLE: begin
        w_send_com = !w_com_done;
        w_link_win = w_com_done;
      end
      ST_LINK: begin
        w_link_win = 1'b1;
      end
      default: begin
        w_send_com = 1'b0;
        w_link_win = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (!reset) begin
      r_com_cnt <= '0;
    end else if (w_load && w_send_com) begin
      r_com_cnt <= r_com_cnt + CCW'(1);
    end
  end

`ifdef COM_PERIODIC_EN
  localparam int IW = $clog2(COM_PERIOD + 1);

  logic [IW-1:0] r_idle_cnt;

  assign w_period_com = !r_pend && (r_idle_cnt == IW'(COM_PERIOD));

  always_ff @(posedge clk_1) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (w_load && !w_send_com) begin
      if (r_pend || w_period_com) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + IW'(1);
      end
    end
  end
`else
  logic w_unused_period;

  assign w_period_com    = 1'b0;
  assign w_unused_period = (COM_PERIOD > 0);
`endif

  always_comb begin
    w_sym = SYM_IDLE;
    if (w_send_com || w_period_com) begin
      w_sym = SYM_COM;
    end else if (r_pend) begin
      w_sym = r_data;
    end
  end

  // Capture happens in bit slot 7, the load one clock later, so the two never collide.
  always_ff @(posedge clk_1) begin
    if (!reset) begin
      r_pend <= 1'b0;
      r_data <= 8'h00;
    end else if (w_xfer) begin
      r_pend <= 1'b1;
      r_data <= data_in;
    end else if (w_load && !w_send_com) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_1) begin
    if (!reset) begin
      r_ready  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_ready <= w_link_win && (w_bit_cnt == 3'd6);
      if (w_load && !w_send_com) begin
        r_active <= 1'b1;
      end
    end
  end

  piso_shift8 u_piso (
    .i_clk_1     (clk_1),
    .i_reset     (reset),
    .i_sym       (w_sym),
    .o_bit_cnt   (w_bit_cnt),
    .o_load      (w_load),
    .o_serial    (serial_out),
    .o_sym_start (sym_start)
  );

  assign ready_out  = r_ready;
  assign active_out = r_active;

endmodule

// File: tb/tb_paralelo_serial_phytx.sv
// Bench for paralelo_serial_phytx: symbol-level reference model driven by an edge count since reset release.
module tb_paralelo_serial_phytx;

  localparam int CC = 4;
  localparam int CP = 16;

  logic       clk_1 = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       serial_out;
  logic       sym_start;
  logic       active_out;

  paralelo_serial_phytx #(.COM_COUNT(CC), .COM_PERIOD(CP)) dut (
    .clk_1      (clk_1),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .serial_out (serial_out),
    .sym_start  (sym_start),
    .active_out (active_out)
  );

  always #5 clk_1 = ~clk_1;

  int         n_chk = 0;
  int         n_err = 0;
  int         t = 0;          // edges since reset release
  bit         m_ready = 1'b0; // expected ready_out after the latest edge
  bit         m_took = 1'b0;  // a byte was accepted on the latest edge
  int         idle_run = 0;
  logic [7:0] m_sym = 8'h00;  // symbol currently expected on serial_out
  logic [7:0] acc [int];      // accepted byte per symbol index

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, got, exp);
    end
  endtask

  // Symbol k starts on edge 8k+1: COM for the preamble, then the byte accepted on edge 8k, else IDLE.
  task automatic next_symbol(input int k);
    if (k < CC) begin
      m_sym = 8'hBC;
    end else if (acc.exists(k)) begin
      m_sym = acc[k];
      idle_run = 0;
`ifdef COM_PERIODIC_EN
    end else if (idle_run == CP) begin
      m_sym = 8'hBC;
      idle_run = 0;
`endif
    end else begin
      m_sym = 8'h7C;
      idle_run++;
    end
  endtask

  task automatic step();
    bit       took;
    bit       exp_bit;
    took = 1'b0;
    @(posedge clk_1);
    if (!reset) begin
      t = 0;
      acc.delete();
      idle_run = 0;
      m_sym = 8'h00;
    end else begin
      t++;
      if (m_ready && valid_in) begin
        acc[t / 8] = data_in;
        took = 1'b1;
      end
    end
    m_took = took;
    @(negedge clk_1);
    if (t >= 2 && ((t - 2) % 8) == 0) next_symbol((t - 2) / 8);
    exp_bit = 1'b0;
    if (t >= 2) exp_bit = m_sym[7 - ((t - 2) % 8)];
    chk("serial",    {7'd0, serial_out}, {7'd0, exp_bit});
    chk("sym_start", {7'd0, sym_start},  {7'd0, (t >= 2 && ((t - 2) % 8) == 0)});
    chk("ready",     {7'd0, ready_out},  {7'd0, (t >= 8 * CC - 1 && (t % 8) == 7)});
    chk("active",    {7'd0, active_out}, {7'd0, (t >= 8 * CC + 1)});
    m_ready = (t >= 8 * CC - 1) && ((t % 8) == 7);
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    data_in  = b;
    valid_in = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = m_took;
    end
    valid_in = 1'b0;
    chk("send_accepted", {7'd0, done}, 8'd1);
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) step();
    reset = 1'b1;

    // preamble, then a long idle run (periodic COM shows up here when enabled)
    repeat (224) step();

    send(8'hA5);
    repeat (16) step();

    send(8'h01);
    send(8'h02);
    send(8'h03);
    repeat (12) step();

    // one-clock valid pulse while ready_out is low must be ignored
    for (int i = 0; i < 8 && (t % 8) != 6; i++) step();
    data_in  = 8'hC3;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (16) step();

    for (int i = 0; i < 400; i++) begin
      if (!valid_in && $urandom_range(0, 2) == 0) begin
        valid_in = 1'b1;
        data_in  = 8'($urandom);
      end
      step();
      if (m_took) valid_in = 1'b0;
    end
    valid_in = 1'b0;
    repeat (10) step();

    // reset in bit 3 of a DATA symbol, held 2 clocks
    send(8'h5A);
    repeat (6) step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (48) step();

    // reset right after a capture: the pending byte must never appear
    send(8'h77);
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (48) step();

    send(8'h3C);
    repeat (16) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_phytx.md
PARALELO_SERIAL_PHYTX -- requirements
Module: paralelo_serial_phytx

Interface
REQ-001 Parameter COM_COUNT, default 4: number of COM symbols sent after reset before IDLE or data may be sent.
REQ-002 Parameter COM_PERIOD, default 16: number of consecutive IDLE symbols after which one COM is re-inserted (COM_PERIODIC_EN only).
REQ-003 clk_1  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset==0 on a clk_1 edge resets the block.
REQ-005 data_in  input  8  parallel data symbol to serialize.
REQ-006 valid_in  input  1  data_in holds a symbol to send.
REQ-007 ready_out  output  1  block accepts data_in on this edge if valid_in=1.
REQ-008 serial_out  output  1  serial bit stream, MSB of each symbol first, one bit per clk_1.
REQ-009 sym_start  output  1  high while serial_out carries bit 7 of a symbol.
REQ-010 active_out  output  1  high once the COM preamble is complete.

Function
REQ-011 Symbols: COM = 0xBC, IDLE = 0x7C, DATA = the captured data_in byte.
REQ-012 A 3-bit counter bit_cnt (0..7) shall advance every clock outside reset and wrap 7->0; serial_out is registered: serial_out <= cur_sym[7-bit_cnt].
REQ-013 cur_sym shall be selected only on the edge where bit_cnt==0, and shall be held for exactly 8 clocks.
REQ-014 FSM states: PREAMBLE, LINK; reset enters PREAMBLE with com_cnt=0.
REQ-015 PREAMBLE: each symbol is COM; com_cnt increments per symbol (saturating at COM_COUNT); after COM_COUNT COMs the state shall be LINK at the next symbol boundary.
REQ-016 LINK: each symbol is DATA if a byte was accepted during the previous symbol, else IDLE.
REQ-017 ready_out shall equal 1 only when state==LINK (or the final PREAMBLE symbol is in flight) and bit_cnt==7; it is 0 at all other times.
REQ-018 Transfer occurs when valid_in=1 and ready_out=1 on the same edge; data_in is captured and is the next symbol; at most one byte per symbol; back-to-back transfers give gap-free DATA symbols.
REQ-019 valid_in with ready_out=0 shall be ignored (no capture, no error); the source holds data_in/valid_in until ready_out.
REQ-020 active_out shall rise on the same edge that the first non-COM-preamble symbol starts and stay 1 until reset.
REQ-021 sym_start shall be 1 exactly when serial_out carries bit 7 of any symbol.
REQ-022 Latency: byte accepted on edge N appears as MSB on serial_out after edge N+2 (sym_start high), last bit after edge N+9.

Reset
REQ-023 On reset==0: serial_out=0, sym_start=0, ready_out=0, active_out=0, bit_cnt=0, com_cnt=0, idle_cnt=0, state=PREAMBLE, any captured byte discarded.
REQ-024 Reset mid-symbol shall abort the symbol immediately; on release the first bit sent is COM bit 7.

Configuration
REQ-025 Macro COM_PERIODIC_EN defined: in LINK, idle_cnt counts consecutive IDLE symbols; when it reaches COM_PERIOD, the next symbol with no pending data is COM and idle_cnt clears; a DATA symbol clears idle_cnt; ready_out is unaffected.
REQ-026 Macro COM_PERIODIC_EN undefined: no idle_cnt, no COM after the preamble; LINK sends only DATA/IDLE.

Structure
REQ-027 Shared package phy_pkg shall hold SYM_COM (0xBC), SYM_IDLE (0x7C), the FSM state typedef and the COM_COUNT default, shared with the receiver.
REQ-028 One sub-module, piso_shift8 (8-bit load/shift, MSB first, bit counter and sym_start), shall be instantiated; FSM, handshake and symbol selection live in the top.

Verification
REQ-029 Release reset, valid_in=0, 64 clocks -> serial_out = 4x 0xBC then 4x 0x7C, active_out rises at clock 33 boundary.
REQ-030 After preamble, valid_in=1 data_in=0xA5 held -> accepted at first ready_out, next symbol 10100101, then 0x7C once valid_in drops.
REQ-031 valid_in=1 continuously with 0x01,0x02,0x03 -> three contiguous DATA symbols, ready_out pulsing every 8 clocks, no IDLE between.
REQ-032 reset=0 at bit 3 of a DATA symbol for 2 clocks -> outputs zero on the following edge; after release 4 COMs restart, pending byte lost.
REQ-033 COM_PERIODIC_EN, COM_PERIOD=16, valid_in=0 -> after preamble 16x 0x7C, 1x 0xBC, repeating; undefined build -> 0x7C only.
REQ-034 valid_in pulsed high one clock while ready_out=0 -> no capture, stream stays 0x7C.
